xrv1_mem_arb: RTL and testbench

XRV1_MEM_ARB -- requirements
Module: xrv1_mem_arb

---
 rtl/xrv1_pkg.sv | 19 +
 rtl/xrv1_tag_fifo.sv | 52 +++++
 rtl/xrv1_mem_arb.sv | 101 ++++++++++
 tb/tb_xrv1_mem_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv1_pkg.sv
// Shared types for the xrv1 memory arbiter: requester source tags, the default
// number of outstanding requests and the request bundle used by the arbiter mux.
package xrv1_pkg;

    localparam int MAX_OUTST_DEF = 2;

    typedef enum logic {
        SRC_IMEM = 1'b0,
        SRC_DMEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        w_en;
        logic [3:0]  w_be;
        logic [31:0] w_data;
    } mem_req_t;

endpackage

// File: rtl/xrv1_tag_fifo.sv
// In-order tag FIFO. Pointers wrap modulo DEPTH, so non-power-of-two depths work.
module xrv1_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wrap_inc(wr_ptr);
            if (pop_i)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];

endmodule

// File: rtl/xrv1_mem_arb.sv
// Round-robin arbiter sharing one TCM port between instruction and data requesters;
// responses return in order and are steered back using a FIFO of source tags.
module xrv1_mem_arb
    import xrv1_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        imem_req_vld_i,
    output logic        imem_req_rdy_o,
    input  logic [31:0] imem_req_addr_i,
    output logic        imem_resp_vld_o,
    output logic [31:0] imem_resp_data_o,

    input  logic        dmem_req_vld_i,
    output logic        dmem_req_rdy_o,
    input  logic [31:0] dmem_req_addr_i,
    input  logic        dmem_req_w_en_i,
    input  logic [3:0]  dmem_req_w_be_i,
    input  logic [31:0] dmem_req_w_data_i,
    output logic        dmem_resp_vld_o,
    output logic        dmem_resp_err_o,
    output logic [31:0] dmem_resp_r_data_o,

    output logic        mem_req_vld_o,
    input  logic        mem_req_rdy_i,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_w_en_o,
    output logic [3:0]  mem_req_w_be_o,
    output logic [31:0] mem_req_w_data_o,
    input  logic        mem_resp_vld_i,
    input  logic        mem_resp_err_i,
    input  logic [31:0] mem_resp_r_data_i,

    output logic        proto_err_o
);

    logic       full, empty;
    logic       prio_dmem;
    logic       grant_imem, grant_dmem;
    logic       accept, pop, head_is_dmem;
    logic [0:0] push_tag, head_tag;
    mem_req_t   ireq, dreq, greq;

    // prio_dmem is 1 when imem was granted last (or after reset).
    assign grant_dmem = dmem_req_vld_i & (prio_dmem | ~imem_req_vld_i);
    assign grant_imem = imem_req_vld_i & ~grant_dmem;

    assign ireq = '{addr: imem_req_addr_i, w_en: 1'b0, w_be: 4'h0, w_data: 32'h0};
    assign dreq = '{addr: dmem_req_addr_i, w_en: dmem_req_w_en_i,
                    w_be: dmem_req_w_be_i, w_data: dmem_req_w_data_i};
    assign greq = grant_dmem ? dreq : ireq;

    assign mem_req_vld_o    = (imem_req_vld_i | dmem_req_vld_i) & ~full & ~rst_i;
    assign mem_req_addr_o   = greq.addr;
    assign mem_req_w_en_o   = greq.w_en;
    assign mem_req_w_be_o   = greq.w_be;
    assign mem_req_w_data_o = greq.w_data;

    assign imem_req_rdy_o = grant_imem & mem_req_rdy_i & ~full & ~rst_i;
    assign dmem_req_rdy_o = grant_dmem & mem_req_rdy_i & ~full & ~rst_i;

    assign accept   = mem_req_vld_o & mem_req_rdy_i;
    assign push_tag = grant_dmem ? 1'(SRC_DMEM) : 1'(SRC_IMEM);
    assign pop      = mem_resp_vld_i & ~empty;

    assign head_is_dmem = ~empty & (src_e'(head_tag) == SRC_DMEM);

    assign imem_resp_vld_o    = pop & ~head_is_dmem & ~rst_i;
    assign dmem_resp_vld_o    = pop & head_is_dmem & ~rst_i;
    assign dmem_resp_err_o    = mem_resp_err_i & head_is_dmem & mem_resp_vld_i;
    assign imem_resp_data_o   = mem_resp_r_data_i;
    assign dmem_resp_r_data_o = mem_resp_r_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_dmem   <= 1'b1;
            proto_err_o <= 1'b0;
        end else begin
            if (accept) prio_dmem <= grant_imem;
            if (mem_resp_vld_i & empty) proto_err_o <= 1'b1;
        end
    end

    xrv1_tag_fifo #(
        .DEPTH(MAX_OUTST),
        .WIDTH(1)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (push_tag),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head_tag)
    );

endmodule

// File: tb/tb_xrv1_mem_arb.sv
// Self-checking bench for xrv1_mem_arb: directed vector table, reset corner cases,
// and randomized traffic against a queue-based reference model.
module tb_xrv1_mem_arb;
    import xrv1_pkg::*;

    localparam int MO = 2;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_vld_i, imem_req_rdy_o, imem_resp_vld_o;
    logic [31:0] imem_req_addr_i, imem_resp_data_o;
    logic        dmem_req_vld_i, dmem_req_rdy_o, dmem_req_w_en_i;
    logic [3:0]  dmem_req_w_be_i;
    logic [31:0] dmem_req_addr_i, dmem_req_w_data_i, dmem_resp_r_data_o;
    logic        dmem_resp_vld_o, dmem_resp_err_o;
    logic        mem_req_vld_o, mem_req_rdy_i, mem_req_w_en_o;
    logic [31:0] mem_req_addr_o, mem_req_w_data_o, mem_resp_r_data_i;
    logic [3:0]  mem_req_w_be_o;
    logic        mem_resp_vld_i, mem_resp_err_i;
    logic        proto_err_o;

    always #5 clk_i = ~clk_i;

    xrv1_mem_arb #(.MAX_OUTST(MO)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .imem_req_vld_i     (imem_req_vld_i),
        .imem_req_rdy_o     (imem_req_rdy_o),
        .imem_req_addr_i    (imem_req_addr_i),
        .imem_resp_vld_o    (imem_resp_vld_o),
        .imem_resp_data_o   (imem_resp_data_o),
        .dmem_req_vld_i     (dmem_req_vld_i),
        .dmem_req_rdy_o     (dmem_req_rdy_o),
        .dmem_req_addr_i    (dmem_req_addr_i),
        .dmem_req_w_en_i    (dmem_req_w_en_i),
        .dmem_req_w_be_i    (dmem_req_w_be_i),
        .dmem_req_w_data_i  (dmem_req_w_data_i),
        .dmem_resp_vld_o    (dmem_resp_vld_o),
        .dmem_resp_err_o    (dmem_resp_err_o),
        .dmem_resp_r_data_o (dmem_resp_r_data_o),
        .mem_req_vld_o      (mem_req_vld_o),
        .mem_req_rdy_i      (mem_req_rdy_i),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_w_en_o     (mem_req_w_en_o),
        .mem_req_w_be_o     (mem_req_w_be_o),
        .mem_req_w_data_o   (mem_req_w_data_o),
        .mem_resp_vld_i     (mem_resp_vld_i),
        .mem_resp_err_i     (mem_resp_err_i),
        .mem_resp_r_data_i  (mem_resp_r_data_i),
        .proto_err_o        (proto_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] iv, ia, dv, da, dwe, dbe, dwd, rdy, rv, rerr, rdata;
        logic [31:0] mvld, maddr, mwe, mbe, mwd, irdy, drdy, irv, drv, derr, perr;
    } vec_t;

    vec_t vec[14];

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        imem_req_vld_i = 0; imem_req_addr_i = 0;
        dmem_req_vld_i = 0; dmem_req_addr_i = 0; dmem_req_w_en_i = 0;
        dmem_req_w_be_i = 0; dmem_req_w_data_i = 0;
        mem_req_rdy_i = 0; mem_resp_vld_i = 0; mem_resp_err_i = 0; mem_resp_r_data_i = 0;
    endtask

    task automatic drive(input vec_t v);
        imem_req_vld_i    = v.iv[0];
        imem_req_addr_i   = v.ia;
        dmem_req_vld_i    = v.dv[0];
        dmem_req_addr_i   = v.da;
        dmem_req_w_en_i   = v.dwe[0];
        dmem_req_w_be_i   = v.dbe[3:0];
        dmem_req_w_data_i = v.dwd;
        mem_req_rdy_i     = v.rdy[0];
        mem_resp_vld_i    = v.rv[0];
        mem_resp_err_i    = v.rerr[0];
        mem_resp_r_data_i = v.rdata;
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        chk($sformatf("vec%0d mem_req_vld", i), 32'(mem_req_vld_o), v.mvld);
        chk($sformatf("vec%0d imem_rdy", i), 32'(imem_req_rdy_o), v.irdy);
        chk($sformatf("vec%0d dmem_rdy", i), 32'(dmem_req_rdy_o), v.drdy);
        chk($sformatf("vec%0d imem_resp_vld", i), 32'(imem_resp_vld_o), v.irv);
        chk($sformatf("vec%0d dmem_resp_vld", i), 32'(dmem_resp_vld_o), v.drv);
        chk($sformatf("vec%0d dmem_resp_err", i), 32'(dmem_resp_err_o), v.derr);
        chk($sformatf("vec%0d proto_err", i), 32'(proto_err_o), v.perr);
        if (v.mvld[0]) begin
            chk($sformatf("vec%0d addr", i), mem_req_addr_o, v.maddr);
            chk($sformatf("vec%0d w_en", i), 32'(mem_req_w_en_o), v.mwe);
            chk($sformatf("vec%0d w_be", i), 32'(mem_req_w_be_o), v.mbe);
            chk($sformatf("vec%0d w_data", i), mem_req_w_data_o, v.mwd);
        end
        if (v.rv[0]) begin
            chk($sformatf("vec%0d imem_data", i), imem_resp_data_o, v.rdata);
            chk($sformatf("vec%0d dmem_data", i), dmem_resp_r_data_o, v.rdata);
        end
    endtask

    // Asserts reset for two edges with every input active; handshakes must stay low.
    task automatic do_reset;
        rst_i = 1;
        imem_req_vld_i = 1; dmem_req_vld_i = 1; mem_req_rdy_i = 1; mem_resp_vld_i = 1;
        @(negedge clk_i);
        chk("rst mem_req_vld", 32'(mem_req_vld_o), 0);
        chk("rst imem_rdy", 32'(imem_req_rdy_o), 0);
        chk("rst dmem_rdy", 32'(dmem_req_rdy_o), 0);
        chk("rst imem_resp_vld", 32'(imem_resp_vld_o), 0);
        chk("rst dmem_resp_vld", 32'(dmem_resp_vld_o), 0);
        tick;
        tick;
        rst_i = 0;
        idle;
    endtask

    // Reference model: outstanding sources in order, last granted source, sticky error.
    int q[$];
    int last;
    bit perr_m;

    task automatic model_reset;
        q.delete();
        last = 0;
        perr_m = 0;
    endtask

    initial begin
        int gnt;
        bit e_mvld, e_irv, e_drv, e_derr, full, any;
        rst_i = 1;
        idle;
        tick;
        do_reset;
        @(negedge clk_i);
        chk("post_rst proto_err", 32'(proto_err_o), 0);
        chk("post_rst mem_req_vld", 32'(mem_req_vld_o), 0);
        tick;

        //        iv ia      dv da      we be   wd  rdy rv rerr rdata          mvld maddr  we be   wd  irdy drdy irv drv derr perr
        vec[0]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 0, 0, 0,            1,'h200, 1,'hF, A5, 0, 1, 0, 0, 0, 0};
        vec[1]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 1, 0, 'h12345678,   1,'h100, 0, 0,  0,  1, 0, 0, 1, 0, 0};
        vec[2]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 1, 1, 'hDEADBEEF,   1,'h200, 1,'hF, A5, 0, 1, 1, 0, 0, 0};
        vec[3]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 1, 1, 'h12345678,   1,'h100, 0, 0,  0,  1, 0, 0, 1, 1, 0};
        vec[4]  = '{1,'h100, 1,'h200, 1,'hF, A5, 0, 0, 0, 0,            1,'h200, 1,'hF, A5, 0, 0, 0, 0, 0, 0};
        vec[5]  = '{1,'h100, 1,'h200, 1,'hF, A5, 0, 0, 0, 0,            1,'h200, 1,'hF, A5, 0, 0, 0, 0, 0, 0};
        vec[6]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 0, 0, 0,            1,'h200, 1,'hF, A5, 0, 1, 0, 0, 0, 0};
        vec[7]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 0, 0, 0,            0, 0,    0, 0,  0,  0, 0, 0, 0, 0, 0};
        vec[8]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 1, 0, 'h55,         0, 0,    0, 0,  0,  0, 0, 1, 0, 0, 0};
        vec[9]  = '{1,'h100, 1,'h200, 1,'hF, A5, 1, 0, 0, 0,            1,'h100, 0, 0,  0,  1, 0, 0, 0, 0, 0};
        vec[10] = '{0,'h100, 0,'h200, 1,'hF, A5, 1, 1, 0, 'h77,         0, 0,    0, 0,  0,  0, 0, 0, 1, 0, 0};
        vec[11] = '{0, 0,    0, 0,    0, 0,  0,  1, 1, 0, 'h88,         0, 0,    0, 0,  0,  0, 0, 1, 0, 0, 0};
        vec[12] = '{0, 0,    0, 0,    0, 0,  0,  1, 1, 1, 'h99,         0, 0,    0, 0,  0,  0, 0, 0, 0, 0, 0};
        vec[13] = '{0, 0,    0, 0,    0, 0,  0,  1, 0, 0, 0,            0, 0,    0, 0,  0,  0, 0, 0, 0, 0, 1};

        for (int i = 0; i < 14; i++) begin
            drive(vec[i]);
            @(negedge clk_i);
            chk_vec(i, vec[i]);
            tick;
        end

        // Sticky protocol error clears only on reset.
        do_reset;
        @(negedge clk_i);
        chk("perr cleared by rst", 32'(proto_err_o), 0);
        tick;

        // Two requests in flight across a reset: their late responses are dropped.
        imem_req_vld_i = 1; imem_req_addr_i = 32'h300; mem_req_rdy_i = 1;
        @(negedge clk_i);
        chk("inflight imem_rdy", 32'(imem_req_rdy_o), 1);
        tick;
        imem_req_vld_i = 0; dmem_req_vld_i = 1; dmem_req_addr_i = 32'h400;
        @(negedge clk_i);
        chk("inflight dmem_rdy", 32'(dmem_req_rdy_o), 1);
        tick;
        dmem_req_vld_i = 0; imem_req_vld_i = 1;
        @(negedge clk_i);
        chk("inflight full imem_rdy", 32'(imem_req_rdy_o), 0);
        tick;
        do_reset;
        mem_resp_vld_i = 1; mem_resp_r_data_i = 32'hCAFE0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk($sformatf("dropped%0d imem_resp_vld", k), 32'(imem_resp_vld_o), 0);
            chk($sformatf("dropped%0d dmem_resp_vld", k), 32'(dmem_resp_vld_o), 0);
            tick;
        end
        mem_resp_vld_i = 0;
        @(negedge clk_i);
        chk("dropped proto_err", 32'(proto_err_o), 1);
        tick;

        // Randomized traffic against the reference model.
        do_reset;
        model_reset;
        for (int n = 0; n < 500; n++) begin
            imem_req_vld_i    = ($urandom_range(0, 2) != 0);
            imem_req_addr_i   = $urandom;
            dmem_req_vld_i    = ($urandom_range(0, 2) != 0);
            dmem_req_addr_i   = $urandom;
            dmem_req_w_en_i   = 1'($urandom_range(0, 1));
            dmem_req_w_be_i   = 4'($urandom_range(0, 15));
            dmem_req_w_data_i = $urandom;
            mem_req_rdy_i     = ($urandom_range(0, 3) != 0);
            mem_resp_vld_i    = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            mem_resp_err_i    = 1'($urandom_range(0, 1));
            mem_resp_r_data_i = $urandom;

            full = (q.size() >= MO);
            any  = imem_req_vld_i | dmem_req_vld_i;
            e_mvld = any && !full;
            if (imem_req_vld_i && dmem_req_vld_i) gnt = (last == 1) ? 0 : 1;
            else gnt = dmem_req_vld_i ? 1 : 0;
            e_irv = mem_resp_vld_i && q.size() > 0 && q[0] == 0;
            e_drv = mem_resp_vld_i && q.size() > 0 && q[0] == 1;
            e_derr = e_drv && mem_resp_err_i;

            @(negedge clk_i);
            chk("rnd mem_req_vld", 32'(mem_req_vld_o), 32'(e_mvld));
            chk("rnd imem_rdy", 32'(imem_req_rdy_o), 32'(e_mvld && gnt == 0 && mem_req_rdy_i));
            chk("rnd dmem_rdy", 32'(dmem_req_rdy_o), 32'(e_mvld && gnt == 1 && mem_req_rdy_i));
            chk("rnd imem_resp_vld", 32'(imem_resp_vld_o), 32'(e_irv));
            chk("rnd dmem_resp_vld", 32'(dmem_resp_vld_o), 32'(e_drv));
            chk("rnd dmem_resp_err", 32'(dmem_resp_err_o), 32'(e_derr));
            chk("rnd proto_err", 32'(proto_err_o), 32'(perr_m));
            if (e_mvld) begin
                chk("rnd addr", mem_req_addr_o, gnt == 1 ? dmem_req_addr_i : imem_req_addr_i);
                chk("rnd w_en", 32'(mem_req_w_en_o), gnt == 1 ? 32'(dmem_req_w_en_i) : 0);
                chk("rnd w_be", 32'(mem_req_w_be_o), gnt == 1 ? 32'(dmem_req_w_be_i) : 0);
                chk("rnd w_data", mem_req_w_data_o, gnt == 1 ? dmem_req_w_data_i : 0);
            end
            if (e_irv) chk("rnd imem_data", imem_resp_data_o, mem_resp_r_data_i);
            if (e_drv) chk("rnd dmem_data", dmem_resp_r_data_o, mem_resp_r_data_i);

            @(posedge clk_i);
            if (mem_resp_vld_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else perr_m = 1;
            end
            if (e_mvld && mem_req_rdy_i) begin
                q.push_back(gnt);
                last = gnt;
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
